// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//
// Arbitrates two requesters onto one shared, external, combinational ALU.
// Only one operation is in flight at a time. The FSM runs IDLE -> EXEC -> RESP
// -> IDLE:
//   IDLE : grant one requester and latch its sel/a/b into the operand register.
//   EXEC : the ALU is driven from the operand register for one cycle. Its
//          result and flags are captured at the closing edge.
//   RESP : the owner's rsp_valid is held until the owner's rsp_ready is seen.
// Each operation takes at least three cycles. rsp_valid rises two edges after
// the accept edge.
//
// Select codes 14 and 15 are undefined for the shared ALU. For these codes the
// result is forced to zero, the flags are forced to zero, and err is set.
//
// Configuration:
//   ALU_SHARE_ARB_RR_EN defined   : round-robin. When both requesters are
//                                   valid, the one not accepted last wins.
//   ALU_SHARE_ARB_RR_EN undefined : fixed priority. Requester 0 always wins.
//
// Ports:
//   clk, rst                         clock; asynchronous active-high reset
//   reqN_valid/ready/sel/a/b         request handshake and operands, N = 0,1
//   alu_sel, alu_a, alu_b            drive the shared ALU (from operand reg)
//   alu_out, alu_flags               shared ALU result and
//                                    {carry,zero,negative,overflow,underflow}
//   rspN_valid/ready/data/flags/err  response handshake and payload, N = 0,1
// -----------------------------------------------------------------------------
module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic [SEL_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flags,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [4:0]        rsp0_flags,
  output logic              rsp0_err,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [4:0]        rsp1_flags,
  output logic              rsp1_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] SEL_UNDEF_LO = SEL_W'(14);
  localparam logic [SEL_W-1:0] SEL_UNDEF_HI = SEL_W'(15);

  state_t            state_q, state_d;

  logic [SEL_W-1:0]  op_sel_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic              op_owner_q;

  logic [DATA_W-1:0] res_data_q;
  logic [4:0]        res_flags_q;
  logic              res_err_q;

  logic              grant0, grant1;
  logic              accept0, accept1, accept;
  logic              owner_ready;
  logic              sel_undef;

  // ---------------------------------------------------------------------------
  // Grant selection (evaluated every cycle; used only while IDLE)
  // ---------------------------------------------------------------------------
`ifdef ALU_SHARE_ARB_RR_EN
  // last_q is the requester accepted most recently. It resets to 1 so that
  // requester 0 wins the first contention.
  logic last_q;

  always_comb begin
    grant0 = req0_valid & (~req1_valid |  last_q);
    grant1 = req1_valid & (~req0_valid | ~last_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_q <= 1'b1;
    else if (accept) last_q <= accept1;
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`endif

  assign accept0     = req0_valid & req0_ready;
  assign accept1     = req1_valid & req1_ready;
  assign accept      = accept0 | accept1;
  assign owner_ready = op_owner_q ? rsp1_ready : rsp0_ready;
  assign sel_undef   = (op_sel_q == SEL_UNDEF_LO) || (op_sel_q == SEL_UNDEF_HI);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: state elements use non-blocking assignments so that every flop
  // samples pre-edge values, independent of the order in which blocks run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so that no path through the
  // block leaves it unassigned. An unassigned path would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (owner_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // ready is qualified with rst so that it drops the moment reset is raised,
  // even while a requester is holding valid.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          req0_ready = grant0;
          req1_ready = grant1;
        end
        S_RESP: begin
          rsp0_valid = ~op_owner_q;
          rsp1_valid =  op_owner_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand register: loaded on the accept edge and drives the ALU at all times
  // ---------------------------------------------------------------------------
  // NOTE: these are plain registers, not memories. They are reset so that the
  // ALU inputs and the response payload read as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sel_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_owner_q <= 1'b0;
    end else if (state_q == S_IDLE && accept) begin
      op_owner_q <= accept1;
      op_sel_q   <= accept1 ? req1_sel : req0_sel;
      op_a_q     <= accept1 ? req1_a   : req0_a;
      op_b_q     <= accept1 ? req1_b   : req0_b;
    end
  end

  assign alu_sel = op_sel_q;
  assign alu_a   = op_a_q;
  assign alu_b   = op_b_q;

  // ---------------------------------------------------------------------------
  // Result register: captured at the edge that closes EXEC
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_err_q   <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_data_q  <= sel_undef ? '0   : alu_out;
      res_flags_q <= sel_undef ? 5'b0 : alu_flags;
      res_err_q   <= sel_undef;
    end
  end

  // Both requesters see the single result register. Ownership is signalled
  // only through rsp_valid.
  assign rsp0_data  = res_data_q;
  assign rsp0_flags = res_flags_q;
  assign rsp0_err   = res_err_q;
  assign rsp1_data  = res_data_q;
  assign rsp1_flags = res_flags_q;
  assign rsp1_err   = res_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_sel, req1_sel;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_flags;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [4:0]  rsp0_flags, rsp1_flags;
  logic        rsp0_err, rsp1_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.DATA_W(32), .SEL_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err)
  );

  // Stand-in for the shared ALU. Flags are {carry,zero,negative,overflow,underflow}.
  // sel 0 AND, 1 OR, 2 ADD, 3 XOR, 6 SUB, any other sel passes a through.
  logic [31:0] m_res;
  logic        m_c, m_o, m_u;
  always_comb begin
    m_res = '0; m_c = 1'b0; m_o = 1'b0; m_u = 1'b0;
    case (alu_sel)
      4'd0: m_res = alu_a & alu_b;
      4'd1: m_res = alu_a | alu_b;
      4'd2: begin
        {m_c, m_res} = {1'b0, alu_a} + {1'b0, alu_b};
        m_o = (alu_a[31] == alu_b[31]) && (m_res[31] != alu_a[31]);
      end
      4'd3: m_res = alu_a ^ alu_b;
      4'd6: begin
        m_res = alu_a - alu_b;
        m_c   = alu_a < alu_b;
        m_u   = (alu_a[31] != alu_b[31]) && (m_res[31] != alu_a[31]);
      end
      default: m_res = alu_a;
    endcase
  end
  assign alu_out   = m_res;
  assign alu_flags = {m_c, (m_res == 32'd0), m_res[31], m_o, m_u};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Runs one full operation. Called at posedge+1 with the DUT in IDLE.
  task automatic do_op(input logic n, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_data,
                       input logic [4:0] exp_flags, input logic exp_err);
    if (!n) begin req0_valid = 1'b1; req0_sel = sel; req0_a = a; req0_b = b; end
    else    begin req1_valid = 1'b1; req1_sel = sel; req1_a = a; req1_b = b; end
    #1;
    check("req_ready_owner", n ? req1_ready : req0_ready, 1);
    check("req_ready_other", n ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;                       // accept edge -> EXEC
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("exec_alu_sel", alu_sel, sel);
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("exec_req_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;                       // second edge -> RESP
    check("resp_valid_owner", n ? rsp1_valid : rsp0_valid, 1);
    check("resp_valid_other", n ? rsp0_valid : rsp1_valid, 0);
    check("resp_data", n ? rsp1_data : rsp0_data, exp_data);
    check("resp_flags", n ? rsp1_flags : rsp0_flags, exp_flags);
    check("resp_err", n ? rsp1_err : rsp0_err, exp_err);
    if (!n) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk); #1;                       // consumed -> IDLE
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check("idle_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
  endtask

  typedef struct {
    logic        owner;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic [4:0]  flags;
    logic        err;
  } vec_t;

  vec_t vecs[11];
  int   order[4];
  int   n_acc;
  int   exp_o;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 4'd2,  32'd5,          32'd7,          32'd12,         5'b00000, 1'b0};
    vecs[1]  = '{1'b1, 4'd6,  32'd3,          32'd3,          32'd0,          5'b01000, 1'b0};
    vecs[2]  = '{1'b0, 4'hE,  32'd1,          32'd1,          32'd0,          5'b00000, 1'b1};
    vecs[3]  = '{1'b1, 4'hF,  32'd2,          32'd3,          32'd0,          5'b00000, 1'b1};
    vecs[4]  = '{1'b0, 4'd2,  32'hFFFF_FFFF,  32'd1,          32'd0,          5'b11000, 1'b0};
    vecs[5]  = '{1'b1, 4'd2,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  5'b00110, 1'b0};
    vecs[6]  = '{1'b0, 4'd6,  32'd0,          32'd1,          32'hFFFF_FFFF,  5'b10100, 1'b0};
    vecs[7]  = '{1'b1, 4'd6,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  5'b00001, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  5'b00000, 1'b0};
    vecs[9]  = '{1'b1, 4'd3,  32'hAAAA_AAAA,  32'h5555_5555,  32'hFFFF_FFFF,  5'b00100, 1'b0};
    vecs[10] = '{1'b0, 4'd13, 32'h1234_5678,  32'd9,          32'h1234_5678,  5'b00000, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_sel = '0; req1_sel = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state
    #1;
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_rsp_data", rsp0_data, 0);
    check("rst_rsp_err", {rsp0_err, rsp1_err}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Table of single operations. The first one is accepted at the first edge after release.
    for (int i = 0; i < 11; i++)
      do_op(vecs[i].owner, vecs[i].sel, vecs[i].a, vecs[i].b,
            vecs[i].data, vecs[i].flags, vecs[i].err);

    // A valid pulse that drops before any edge must not be latched.
    req0_valid = 1'b1; req0_sel = 4'd2; req0_a = 32'd99; req0_b = 32'd1;
    #2; req0_valid = 1'b0;
    @(posedge clk); #1;
    check("glitch_alu_a", alu_a, 32'h1234_5678);
    @(posedge clk); @(posedge clk); #1;
    check("glitch_rsp_valid", {rsp0_valid, rsp1_valid}, 0);

    // Stalled response: rsp0 is held for 5 cycles, while req1 waits and rsp1_ready is ignored.
    req0_valid = 1'b1; req0_sel = 4'd2; req0_a = 32'd10; req0_b = 32'd20;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_sel = 4'd2; req1_a = 32'd1; req1_b = 32'd1;
    rsp1_ready = 1'b1;
    check("stall_exec_req1_ready", req1_ready, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp0_valid", rsp0_valid, 1);
      check("stall_rsp1_valid", rsp1_valid, 0);
      check("stall_rsp0_data", rsp0_data, 32'd30);
      check("stall_req1_ready", req1_ready, 0);
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    check("stall_release_rsp0_valid", rsp0_valid, 0);
    check("stall_release_req1_ready", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    check("stall_rsp1_valid_after", rsp1_valid, 1);
    check("stall_rsp1_data", rsp1_data, 32'd2);
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    check("stall_done_idle", {rsp0_valid, rsp1_valid}, 0);

    // Both valid continuously for 4 operations. The last accept was requester 1.
    req0_valid = 1'b1; req0_sel = 4'd2; req0_a = 32'd1; req0_b = 32'd0;
    req1_valid = 1'b1; req1_sel = 4'd2; req1_a = 32'd2; req1_b = 32'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    n_acc = 0;
    for (int cyc = 0; cyc < 60 && n_acc < 4; cyc++) begin
      @(negedge clk);
      if (rsp0_valid) check("both_rsp0_data", rsp0_data, 32'd1);
      if (rsp1_valid) check("both_rsp1_data", rsp1_data, 32'd2);
      if (req0_ready && req1_ready) check("both_ready_exclusive", 1, 0);
      if (req0_ready)      begin order[n_acc] = 0; n_acc++; end
      else if (req1_ready) begin order[n_acc] = 1; n_acc++; end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("both_accept_count", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_SHARE_ARB_RR_EN
      exp_o = i % 2;
`else
      exp_o = 0;
`endif
      if (i < n_acc) check("both_accept_order", order[i], exp_o);
    end
    repeat (3) @(posedge clk);
    #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset during EXEC discards the operation.
    req0_valid = 1'b1; req0_sel = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_sel = 4'd2; req1_a = 32'd3; req1_b = 32'd4;
    #2; rst = 1'b1;
    #1;
    check("arst_req1_ready", req1_ready, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_sel", alu_sel, 0);
    check("arst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("arst_rsp_data", rsp0_data, 0);
    check("arst_rsp_flags", rsp0_flags, 0);
    @(posedge clk); @(posedge clk); #1;
    req1_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("arst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    end
    do_op(1'b0, 4'd2, 32'd5, 32'd7, 32'd12, 5'b00000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 SHALL have parameter DATA_W, 32, operand/result width (matches shared ALU).
REQ-002 SHALL have parameter SEL_W, 4, ALU operation-select width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester n has an operation pending.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  arbiter accepts requester n this cycle.
REQ-007 SHALL have ports req0_sel/req1_sel  input  SEL_W  operation code for requester n.
REQ-008 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DATA_W  operands.
REQ-009 SHALL have ports alu_sel, alu_a, alu_b  output  SEL_W/DATA_W/DATA_W  drive the shared ALU.
REQ-010 SHALL have ports alu_out  input  DATA_W and alu_flags  input  5  ALU result and {carry,zero,negative,overflow,underflow}.
REQ-011 SHALL have ports rsp0_valid/rsp1_valid  output  1  result available for requester n.
REQ-012 SHALL have ports rsp0_ready/rsp1_ready  input  1  requester n consumes result.
REQ-013 SHALL have ports rsp0_data/rsp1_data  output  DATA_W, rsp0_flags/rsp1_flags  output  5, rsp0_err/rsp1_err  output  1.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one operation in flight.
REQ-015 IDLE: req_n_ready SHALL be asserted only for the granted requester, combinationally from req_valid and grant pointer; never both.
REQ-016 On req_n_valid & req_n_ready edge: latch sel/a/b and owner n into operand register; go to EXEC.
REQ-017 alu_sel/alu_a/alu_b SHALL be driven from operand register at all times (zeros after reset).
REQ-018 EXEC lasts exactly one cycle; at its closing edge alu_out and alu_flags SHALL be captured into result register; go to RESP.
REQ-019 RESP: rsp_owner_valid high, other rsp_valid low; data/flags/err stable until rsp_owner_ready sampled high, then go to IDLE.
REQ-020 Latency: rsp_valid rises 2 edges after accept edge; minimum 3 cycles per operation.
REQ-021 sel 14 or 15 (ALU undefined): captured data SHALL be 0, flags 0, err=1; all other sel err=0.
REQ-022 No request SHALL be accepted in EXEC or RESP, regardless of req_valid.
REQ-023 req_valid deasserting before acceptance SHALL be tolerated; nothing latched.
REQ-024 rsp_ready asserted outside RESP or by non-owner SHALL be ignored.
REQ-025 Grant pointer SHALL update only on accept edge, to the accepted requester.

Reset
REQ-026 rst high SHALL immediately force state IDLE, all ready/rsp_valid 0, operand/result registers 0, err 0, pointer = requester 1 (so requester 0 wins first).
REQ-027 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response issued after release.
REQ-028 First accept possible at first rising edge after rst deassertion.

Configuration
REQ-029 Macro ALU_SHARE_ARB_RR_EN defined: round-robin; on simultaneous valid, grant the requester not last accepted.
REQ-030 Macro ALU_SHARE_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous valid; pointer logic absent.

Verification
REQ-031 req0 sel=2 a=5 b=7 after reset -> req0_ready=1, rsp0_valid 2 edges later, rsp0_data=12, flags zero=0, err=0.
REQ-032 req1 sel=6 a=3 b=3 -> rsp1_data=0, zero flag=1, rsp0_valid stays 0.
REQ-033 Both valid continuously, 4 ops, RR_EN defined -> accept order 0,1,0,1; undefined -> 0,0,0,0.
REQ-034 req0 sel=4'hE a=1 b=1 -> rsp0_data=0, rsp0_err=1, rsp0_flags=0.
REQ-035 rsp0_ready held 0 for 5 cycles in RESP, req1 valid -> rsp0_data stable, req1_ready=0 until rsp0 consumed.
REQ-036 rst pulsed during EXEC -> all outputs 0 asynchronously, no rsp_valid after release, next req0 accepted normally.
